// File: rtl/qpsk_sym_sequencer.sv
// qpsk_sym_sequencer: paces a serial PN source and hands (I,Q) dibits to the QPSK modulator
module qpsk_sym_sequencer #(
  parameter int BIT_DIV    = 4,
  parameter int FRAME_SYMS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       src_data,
  output logic       src_en,
  output logic       sym_i,
  output logic       sym_q,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] sym_cnt
);
  typedef enum logic [2:0] {IDLE, FETCH_I, FETCH_Q, PRESENT, DONE} state_t;
  state_t     r_state, w_nxt;
  logic [7:0] r_tmr, r_cnt;
  logic       r_hold_i, r_stop, r_sym_i, r_sym_q;
  logic       w_cap, w_tmr_last, w_accept, w_last, w_fetch;
  assign w_fetch    = (r_state == FETCH_I) || (r_state == FETCH_Q);
  assign w_cap      = r_tmr == 8'd2;
  assign w_tmr_last = r_tmr == 8'(BIT_DIV - 1);
  assign w_accept   = (r_state == PRESENT) && sym_ready;
  assign w_last     = (r_cnt + 8'd1 == 8'(FRAME_SYMS)) || r_stop || stop;
  assign sym_i      = r_sym_i;
  assign sym_q      = r_sym_q;
  assign sym_cnt    = r_cnt;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nxt;
  // next state and decoded outputs; Q fetch ends at capture so the symbol is presented immediately
  always_comb begin
    w_nxt      = r_state;
    src_en     = w_fetch && (r_tmr == 8'd0);
    sym_valid  = r_state == PRESENT;
    busy       = r_state != IDLE;
    frame_done = r_state == DONE;
    case (r_state)
      IDLE:    w_nxt = start ? FETCH_I : IDLE;
      FETCH_I: w_nxt = w_tmr_last ? FETCH_Q : FETCH_I;
      FETCH_Q: w_nxt = w_cap ? PRESENT : FETCH_Q;
      PRESENT: w_nxt = sym_ready ? (w_last ? DONE : FETCH_I) : PRESENT;
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end
  // bit timer restarts on every state change so each fetch begins with an enable pulse
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_tmr <= '0;
    else      r_tmr <= (w_nxt != r_state || w_tmr_last) ? '0 : r_tmr + 8'd1;
  // capture the paced source bits; sym_q loads straight from the source on the PRESENT entry edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_hold_i <= 1'b0;
      r_sym_i  <= 1'b0;
      r_sym_q  <= 1'b0;
    end else begin
      if (r_state == FETCH_I && w_cap) r_hold_i <= src_data;
      if (r_state == FETCH_Q && w_cap) {r_sym_i, r_sym_q} <= {r_hold_i, src_data};
    end
  // accepted-symbol count, valid through DONE, cleared once back in IDLE
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else      r_cnt <= (r_state == IDLE || r_state == DONE) ? '0 : w_accept ? r_cnt + 8'd1 : r_cnt;
  // early-stop request held until the frame closes
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_stop <= 1'b0;
    else      r_stop <= (r_state == IDLE) ? 1'b0 : (r_stop | stop);
endmodule

// File: tb/tb_qpsk_sym_sequencer.sv
// tb_qpsk_sym_sequencer: scoreboard bench for the QPSK symbol sequencer with a table-driven PN source
module tb_qpsk_sym_sequencer;
  logic       clk, rst;
  logic [1:0] start, stop, src_data, src_en, sym_i, sym_q, sym_valid, sym_ready, busy, frame_done;
  logic [7:0] sym_cnt [2];
  logic [0:31] pn = 32'b0100_1110_1001_1101_1011_0010_1100_0110;
  logic [4:0] idx [2];
  logic [1:0] d1;
  logic [1:0] exp_a [8] = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b10, 2'b01, 2'b11, 2'b01};
  logic [1:0] exp_b [8] = '{2'b10, 2'b11, 2'b00, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10};
  logic [9:0] q0[$], q1[$];
  logic [7:0] fd0[$], fd1[$];
  int n_cmp = 0, n_bad = 0;
  int ne, fv, e1, e2;
  bit stable;
  logic si, sq;

  qpsk_sym_sequencer #(.BIT_DIV(4), .FRAME_SYMS(8)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .stop(stop[0]), .src_data(src_data[0]),
    .src_en(src_en[0]), .sym_i(sym_i[0]), .sym_q(sym_q[0]), .sym_valid(sym_valid[0]),
    .sym_ready(sym_ready[0]), .busy(busy[0]), .frame_done(frame_done[0]), .sym_cnt(sym_cnt[0]));
  qpsk_sym_sequencer #(.BIT_DIV(3), .FRAME_SYMS(1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .stop(stop[1]), .src_data(src_data[1]),
    .src_en(src_en[1]), .sym_i(sym_i[1]), .sym_q(sym_q[1]), .sym_valid(sym_valid[1]),
    .sym_ready(sym_ready[1]), .busy(busy[1]), .frame_done(frame_done[1]), .sym_cnt(sym_cnt[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data source: enable at cycle c shows on src_data in cycle c+2
  always @(posedge clk or negedge rst)
    if (!rst) begin
      idx[0] <= '0; idx[1] <= '0; d1 <= '0; src_data <= '0;
    end else
      for (int k = 0; k < 2; k++) begin
        if (src_en[k]) begin
          d1[k]  <= pn[idx[k]];
          idx[k] <= idx[k] + 5'd1;
        end
        src_data[k] <= d1[k];
      end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // monitor: pop expected {count, I, Q} on each handshake and expected count on each frame_done
  always @(negedge clk) begin
    if (sym_valid[0] && sym_ready[0])
      if (q0.size() == 0) chk("sym0_unexpected", 32'(q0.size()), 1);
      else chk("sym0", {sym_cnt[0], sym_i[0], sym_q[0]}, q0.pop_front());
    if (frame_done[0])
      if (fd0.size() == 0) chk("done0_unexpected", 32'(fd0.size()), 1);
      else chk("done0_cnt", sym_cnt[0], fd0.pop_front());
    if (sym_valid[1] && sym_ready[1])
      if (q1.size() == 0) chk("sym1_unexpected", 32'(q1.size()), 1);
      else chk("sym1", {sym_cnt[1], sym_i[1], sym_q[1]}, q1.pop_front());
    if (frame_done[1])
      if (fd1.size() == 0) chk("done1_unexpected", 32'(fd1.size()), 1);
      else chk("done1_cnt", sym_cnt[1], fd1.pop_front());
  end

  task automatic push_a(input int n);
    for (int s = 0; s < n; s++) q0.push_back({8'(s), exp_a[s]});
  endtask

  task automatic do_reset;
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
  endtask

  // runs one frame from a negedge; records enable count, first two enable cycles and first valid cycle
  task automatic run_frame(input int k, input int stop_at, input bit hold);
    bit fd = 0;
    ne = 0; fv = 0; e1 = 0; e2 = 0;
    start[k] = 1'b1;
    for (int c = 0; c < 400 && !fd; c++) begin
      @(negedge clk);
      if (!hold) start[k] = 1'b0;
      stop[k] = 1'b0;
      if (sym_valid[k] && fv == 0) fv = c + 1;
      if (src_en[k]) begin
        ne++;
        if (ne == 1) e1 = c + 1;
        if (ne == 2) e2 = c + 1;
        if (ne == stop_at) stop[k] = 1'b1;
      end
      fd = frame_done[k];
    end
    start[k] = 1'b0;
    stop[k]  = 1'b0;
    chk("frame_done_seen", 32'(fd), 1);
  endtask

  task automatic wait_cnt(input logic [7:0] v);
    for (int c = 0; c < 300 && sym_cnt[0] != v; c++) @(negedge clk);
    chk("wait_cnt", sym_cnt[0], v);
  endtask

  task automatic wait_valid;
    for (int c = 0; c < 300 && !sym_valid[0]; c++) @(negedge clk);
    chk("wait_valid", 32'(sym_valid[0]), 1);
  endtask

  task automatic stall_sym2;
    wait_cnt(8'd1);
    sym_ready[0] = 1'b0;
    wait_valid();
    si = sym_i[0]; sq = sym_q[0];
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      stable &= sym_valid[0] && sym_i[0] == si && sym_q[0] == sq && !src_en[0];
    end
    @(posedge clk) #1 sym_ready[0] = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = '0; stop = '0; sym_ready = 2'b11;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {src_en[0], sym_i[0], sym_q[0], sym_valid[0], busy[0], frame_done[0], sym_cnt[0]}, 0);
    rst = 1'b1;
    @(negedge clk);
    // nominal frame
    push_a(8); fd0.push_back(8'd8);
    run_frame(0, 0, 0);
    chk("first_valid_cycle", fv, 8);
    chk("nominal_src_en", ne, 16);
    @(negedge clk) chk("busy_idle", 32'(busy[0]), 0);
    // backpressure on symbol 2
    do_reset();
    push_a(8); fd0.push_back(8'd8);
    fork
      run_frame(0, 0, 0);
      stall_sym2();
    join
    chk("stall_stable", 32'(stable), 1);
    chk("stall_src_en", ne, 16);
    // stop during Q fetch of symbol 3
    do_reset();
    push_a(3); fd0.push_back(8'd3);
    run_frame(0, 6, 0);
    repeat (20) begin
      @(negedge clk);
      if (src_en[0]) ne++;
    end
    chk("stop_src_en", ne, 6);
    // start held high through a frame, then a fresh frame continues the sequence
    do_reset();
    push_a(8); fd0.push_back(8'd8);
    run_frame(0, 0, 1);
    @(negedge clk) chk("held_start_idle", 32'(busy[0]), 0);
    for (int s = 0; s < 8; s++) q0.push_back({8'(s), exp_b[s]});
    fd0.push_back(8'd8);
    run_frame(0, 0, 0);
    // reset while presenting symbol 3
    do_reset();
    push_a(2);
    start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    wait_cnt(8'd2);
    sym_ready[0] = 1'b0;
    wait_valid();
    chk("pre_reset_sym", {sym_i[0], sym_q[0], sym_cnt[0]}, 10'h302);
    rst = 1'b0;
    #1 chk("async_reset", {src_en[0], sym_i[0], sym_q[0], sym_valid[0], busy[0], frame_done[0], sym_cnt[0]}, 0);
    @(negedge clk) rst = 1'b1;
    sym_ready[0] = 1'b1;
    @(negedge clk);
    push_a(8); fd0.push_back(8'd8);
    run_frame(0, 0, 0);
    // BIT_DIV=3, single-symbol frame
    do_reset();
    q1.push_back({8'd0, 2'b01}); fd1.push_back(8'd1);
    run_frame(1, 0, 0);
    chk("bd3_src_en_count", ne, 2);
    chk("bd3_first_en", e1, 1);
    chk("bd3_second_en", e2, 4);
    chk("bd3_valid_cycle", fv, 7);
    @(negedge clk) chk("bd3_busy_idle", 32'(busy[1]), 0);
    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);
    chk("fd0_drained", 32'(fd0.size()), 0);
    chk("fd1_drained", 32'(fd1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
